// File: rtl/alu_exec_unit_if.sv
// Operand/control bundle into the execute unit and its registered results back out.
// master drives operands and controls; slave is the execute unit itself.
interface alu_exec_unit_if;
    logic        in_valid;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        branch;
    logic [31:0] data_in0;
    logic [31:0] data_in1;
    logic [3:0]  operation;
    logic [31:0] result;
    logic        zero;
    logic        take_branch;
    logic        illegal;
    logic        out_valid;

    modport master (
        output in_valid, alu_op, funct, branch, data_in0, data_in1,
        input  operation, result, zero, take_branch, illegal, out_valid
    );

    modport slave (
        input  in_valid, alu_op, funct, branch, data_in0, data_in1,
        output operation, result, zero, take_branch, illegal, out_valid
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU control decode, 32-bit ALU with zero detect and branch gate,
// all outputs registered with one cycle of latency.
module alu_exec_unit (
    input  logic             clk,
    input  logic             reset_n,
    alu_exec_unit_if.slave   bus
);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_NOR = 4'b1100,
        OP_ILL = 4'b1111
    } aluOp_e;

    aluOp_e      opNext;
    logic [31:0] resultNext;
    logic        illegalNext;
    logic        zeroNext;

    always_comb begin
        opNext = OP_ILL;
        case (bus.alu_op)
            2'b00: opNext = OP_ADD;
            2'b01: opNext = OP_SUB;
            2'b11: opNext = OP_OR;
            default: begin
                case (bus.funct)
                    6'b100000: opNext = OP_ADD;
                    6'b100010: opNext = OP_SUB;
                    6'b100100: opNext = OP_AND;
                    6'b100101: opNext = OP_OR;
                    6'b100111: opNext = OP_NOR;
                    6'b101010: opNext = OP_SLT;
                    default:   opNext = OP_ILL;
                endcase
            end
        endcase
    end

    always_comb begin
        resultNext  = '0;
        illegalNext = 1'b0;
        case (opNext)
            OP_AND: resultNext = bus.data_in0 & bus.data_in1;
            OP_OR:  resultNext = bus.data_in0 | bus.data_in1;
            OP_ADD: resultNext = bus.data_in0 + bus.data_in1;
            OP_SUB: resultNext = bus.data_in0 - bus.data_in1;
            OP_SLT: resultNext = {31'b0, ($signed(bus.data_in0) < $signed(bus.data_in1))};
            OP_NOR: resultNext = ~(bus.data_in0 | bus.data_in1);
            default: begin
                resultNext  = '0;
                illegalNext = 1'b1;
            end
        endcase
        zeroNext = (resultNext == '0) && !illegalNext;
    end

    // Data outputs only load on valid edges; out_valid tracks in_valid every edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.operation   <= '0;
            bus.result      <= '0;
            bus.zero        <= 1'b0;
            bus.take_branch <= 1'b0;
            bus.illegal     <= 1'b0;
            bus.out_valid   <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.operation   <= opNext;
                bus.result      <= resultNext;
                bus.zero        <= zeroNext;
                bus.take_branch <= bus.branch & zeroNext;
                bus.illegal     <= illegalNext;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors checked one cycle after each valid edge.
module tb_alu_exec_unit;

    logic clk;
    logic reset_n;
    int unsigned checks;
    int unsigned errors;

    alu_exec_unit_if bus ();

    alu_exec_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkAll(input string tag, input logic [3:0] op, input logic [31:0] res,
                          input logic z, input logic tb, input logic ill, input logic ov);
        chk({tag, ".operation"},   {28'b0, bus.operation}, {28'b0, op});
        chk({tag, ".result"},      bus.result, res);
        chk({tag, ".zero"},        {31'b0, bus.zero}, {31'b0, z});
        chk({tag, ".take_branch"}, {31'b0, bus.take_branch}, {31'b0, tb});
        chk({tag, ".illegal"},     {31'b0, bus.illegal}, {31'b0, ill});
        chk({tag, ".out_valid"},   {31'b0, bus.out_valid}, {31'b0, ov});
    endtask

    // Drive between edges, then sample 1 time unit after the capturing edge.
    task automatic issue(input logic v, input logic [1:0] aop, input logic [5:0] fn,
                         input logic br, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = v;
        bus.alu_op   = aop;
        bus.funct    = fn;
        bus.branch   = br;
        bus.data_in0 = a;
        bus.data_in1 = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.alu_op   = 2'b00;
        bus.funct    = 6'b0;
        bus.branch   = 1'b0;
        bus.data_in0 = '0;
        bus.data_in1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chkAll("por", 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Make outputs non-zero, then reset mid-cycle
        issue(1'b1, 2'b01, 6'b0, 1'b1, 32'h5, 32'h5);
        chkAll("preRst", 4'h6, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chkAll("asyncRst", 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 2'b00, 6'b0, 1'b0, 32'h1, 32'h2);
        chkAll("inRst", 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        issue(1'b0, 2'b00, 6'b0, 1'b0, 32'h1, 32'h2);
        chkAll("postRstIdle", 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // lw/sw address add, funct ignored outside R-type
        issue(1'b1, 2'b00, 6'b000000, 1'b0, 32'h0000_0010, 32'hFFFF_FFFC);
        chkAll("addWrapC", 4'h2, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 2'b00, 6'b101010, 1'b0, 32'hFFFF_FFFF, 32'h1);
        chkAll("addWrap0", 4'h2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

        // beq
        issue(1'b1, 2'b01, 6'b100101, 1'b1, 32'h1234_5678, 32'h1234_5678);
        chkAll("beqTaken", 4'h6, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        issue(1'b1, 2'b01, 6'b100101, 1'b1, 32'h1234_5678, 32'h1234_5679);
        chkAll("beqNot", 4'h6, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);

        // ori path
        issue(1'b1, 2'b11, 6'b100010, 1'b0, 32'hA000_0000, 32'h0000_0005);
        chkAll("ori", 4'h1, 32'hA000_0005, 1'b0, 1'b0, 1'b0, 1'b1);

        // R-type sweep
        issue(1'b1, 2'b10, 6'b100100, 1'b0, 32'hF0F0_00FF, 32'h0F0F_00F0);
        chkAll("rAnd", 4'h0, 32'h0000_00F0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 2'b10, 6'b100101, 1'b0, 32'hF0F0_00FF, 32'h0F0F_00F0);
        chkAll("rOr", 4'h1, 32'hFFFF_00FF, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 2'b10, 6'b100111, 1'b0, 32'hF0F0_00FF, 32'h0F0F_00F0);
        chkAll("rNor", 4'hC, 32'h0000_FF00, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 2'b10, 6'b100010, 1'b0, 32'hF0F0_00FF, 32'h0F0F_00F0);
        chkAll("rSub", 4'h6, 32'hE1E1_000F, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 2'b10, 6'b100000, 1'b0, 32'hF0F0_00FF, 32'h0F0F_00F0);
        chkAll("rAdd", 4'h2, 32'hFFFF_01EF, 1'b0, 1'b0, 1'b0, 1'b1);

        // Signed compare
        issue(1'b1, 2'b10, 6'b101010, 1'b0, 32'hFFFF_FFFF, 32'h1);
        chkAll("sltNeg", 4'h7, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 2'b10, 6'b101010, 1'b1, 32'h1, 32'hFFFF_FFFF);
        chkAll("sltPos", 4'h7, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);

        // Illegal funct blocks the branch even though result is zero
        issue(1'b1, 2'b10, 6'b000000, 1'b1, 32'h1234_5678, 32'h1234_5678);
        chkAll("illegal", 4'hF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Hold with in_valid low while inputs change
        issue(1'b0, 2'b00, 6'b100000, 1'b1, 32'h0000_0001, 32'h0000_0002);
        chkAll("hold1", 4'hF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(1'b0, 2'b01, 6'b100100, 1'b1, 32'h7, 32'h7);
        chkAll("hold2", 4'hF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(1'b0, 2'b11, 6'b100101, 1'b0, 32'hFFFF_0000, 32'h0000_FFFF);
        chkAll("hold3", 4'hF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Recovery after hold
        issue(1'b1, 2'b00, 6'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);
        chkAll("resume", 4'h2, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
